// File: rtl/fp_div_round_pack.sv
// fp_div_round_pack: normalize, round and pack the Newton-Raphson quotient into an IEEE-754 single.
// Define FDIV_RM_EN to honour in_rm; otherwise round-to-nearest-even only.
module fp_div_round_pack #(
  parameter int          EXP_W = 10,
  parameter logic [31:0] QNAN  = 32'h7FC0_0000
)(
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    en,
  input  logic                    in_valid,
  input  logic [31:0]             in_q,
  input  logic signed [EXP_W-1:0] in_exp,
  input  logic                    in_sign,
  input  logic                    in_nan,
  input  logic                    in_inf,
  input  logic                    in_zero,
  input  logic [1:0]              in_rm,
  output logic                    out_valid,
  output logic [31:0]             out_result,
  output logic                    out_of,
  output logic                    out_uf,
  output logic                    out_nx
);
  localparam int EW = EXP_W + 1;
  logic [1:0] rm;
`ifdef FDIV_RM_EN
  assign rm = in_rm;
`else
  logic unused_rm;
  assign rm = 2'b00;
  assign unused_rm = ^in_rm;
`endif
  logic signed [EW-1:0] ex, ne;
  logic [23:0] nm;
  logic ng, ns, ninc, nto_inf;
  always_comb begin
    ex = EW'(in_exp);
    nm = in_q[31] ? in_q[31:8] : in_q[30] ? in_q[30:7] : in_q[29:6];
    ng = in_q[31] ? in_q[7] : in_q[30] ? in_q[6] : in_q[5];
    ns = in_q[31] ? |in_q[6:0] : in_q[30] ? |in_q[5:0] : |in_q[4:0];
    ne = in_q[31] ? ex + EW'(1) : in_q[30] ? ex : ex - EW'(1);
    ninc = rm == 2'b00 ? ng & (ns | nm[0]) :
           rm == 2'b01 ? 1'b0 :
           rm == 2'b10 ? ~in_sign & (ng | ns) : in_sign & (ng | ns);
    nto_inf = (rm == 2'b00) | (rm == 2'b10 & ~in_sign) | (rm == 2'b11 & in_sign);
  end
  logic v1, s1, inc1, nx1, nan1, inf1, zero1, ti1;
  logic [23:0] m1;
  logic signed [EW-1:0] e1;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1 <= 1'b0;
      s1 <= 1'b0;
      m1 <= '0;
      e1 <= '0;
      inc1 <= 1'b0;
      nx1 <= 1'b0;
      nan1 <= 1'b0;
      inf1 <= 1'b0;
      zero1 <= 1'b0;
      ti1 <= 1'b0;
    end else if (en) begin
      v1 <= in_valid;
      s1 <= in_sign;
      m1 <= nm;
      e1 <= ne;
      inc1 <= ninc;
      nx1 <= ng | ns;
      nan1 <= in_nan;
      inf1 <= in_inf;
      zero1 <= in_zero | (in_q == 32'd0);
      ti1 <= nto_inf;
    end
  end
  // A rounding carry out of the 24-bit mantissa renormalizes by one place.
  logic [24:0] m25;
  logic [22:0] mf;
  logic signed [EW-1:0] ef;
  logic sp, ovf, unf;
  logic [31:0] res;
  always_comb begin
    m25 = {1'b0, m1} + 25'(inc1);
    mf = m25[24] ? m25[23:1] : m25[22:0];
    ef = m25[24] ? e1 + EW'(1) : e1;
    sp = nan1 | inf1 | zero1;
    ovf = ~sp & (ef >= EW'(255));
    unf = ~sp & (ef <= EW'(0));
    res = nan1  ? QNAN :
          inf1  ? {s1, 31'h7F80_0000} :
          zero1 ? {s1, 31'd0} :
          ovf   ? (ti1 ? {s1, 31'h7F80_0000} : {s1, 31'h7F7F_FFFF}) :
          unf   ? {s1, 31'd0} : {s1, ef[7:0], mf};
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_result <= '0;
      out_of <= 1'b0;
      out_uf <= 1'b0;
      out_nx <= 1'b0;
    end else if (en) begin
      out_valid <= v1;
      out_result <= res;
      out_of <= ovf;
      out_uf <= unf;
      out_nx <= ~sp & (ovf | unf | nx1);
    end
  end
endmodule

// File: tb/tb_fp_div_round_pack.sv
// tb_fp_div_round_pack: randomized scoreboard bench for the divider round/pack stage.
module tb_fp_div_round_pack;
  logic clk = 0, rst_n = 0, en = 0, in_valid = 0;
  logic in_sign = 0, in_nan = 0, in_inf = 0, in_zero = 0;
  logic [31:0] in_q = 0;
  logic signed [9:0] in_exp = 0;
  logic [1:0] in_rm = 0;
  logic out_valid, out_of, out_uf, out_nx;
  logic [31:0] out_result;
  int checks = 0, failures = 0;
  logic [34:0] expq[$];

  always #5 clk = ~clk;

  fp_div_round_pack dut (
    .clk(clk), .rst_n(rst_n), .en(en), .in_valid(in_valid), .in_q(in_q),
    .in_exp(in_exp), .in_sign(in_sign), .in_nan(in_nan), .in_inf(in_inf),
    .in_zero(in_zero), .in_rm(in_rm), .out_valid(out_valid),
    .out_result(out_result), .out_of(out_of), .out_uf(out_uf), .out_nx(out_nx)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Reference: value-level rounding of q / 2^k with remainder compared against half an ulp.
  function automatic logic [34:0] model(input logic [31:0] q, input int ex, input logic s,
                                        input logic n, input logic i, input logic z,
                                        input logic [1:0] rm_in);
    int k, e;
    longint mant, rem, half;
    bit up, to_inf;
    logic [1:0] rm;
    rm = rm_in;
`ifndef FDIV_RM_EN
    rm = 2'b00;
`endif
    if (n) return {3'b000, 32'h7FC0_0000};
    if (i) return {3'b000, s, 31'h7F80_0000};
    if (z || q == 0) return {3'b000, s, 31'd0};
    k = q[31] ? 8 : q[30] ? 7 : 6;
    mant = longint'(q) >> k;
    rem = longint'(q) & ((longint'(1) << k) - 1);
    half = longint'(1) << (k - 1);
    e = ex + k - 7;
    case (rm)
      2'b00: up = (rem > half) || (rem == half && mant[0]);
      2'b01: up = 0;
      2'b10: up = !s && rem != 0;
      default: up = s && rem != 0;
    endcase
    mant = mant + longint'(up);
    if (mant == (longint'(1) << 24)) begin
      mant = mant >> 1;
      e++;
    end
    to_inf = rm == 2'b00 || (rm == 2'b10 && !s) || (rm == 2'b11 && s);
    if (e >= 255) return {3'b101, to_inf ? {s, 31'h7F80_0000} : {s, 31'h7F7F_FFFF}};
    if (e <= 0) return {3'b011, s, 31'd0};
    return {2'b00, rem != 0, s, e[7:0], mant[22:0]};
  endfunction

  always @(posedge clk) begin
    logic en_s;
    en_s = en;
    #1;
    if (rst_n && en_s && out_valid) begin
      if (expq.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_output actual=%h expected=none", out_result);
      end else chk("result", 64'({out_of, out_uf, out_nx, out_result}), 64'(expq.pop_front()));
    end
  end

  task automatic issue(input logic [31:0] q, input int ex, input logic s, input logic n,
                       input logic i, input logic z, input logic [1:0] rm, input logic [34:0] exp);
    @(negedge clk);
    en = 1; in_valid = 1; in_q = q; in_exp = 10'(ex); in_sign = s;
    in_nan = n; in_inf = i; in_zero = z; in_rm = rm;
    expq.push_back(exp);
  endtask

  task automatic rnd_issue();
    logic [31:0] q;
    int ex, sel;
    logic s, n, i, z;
    logic [1:0] rm;
    q = $urandom;
    sel = $urandom_range(0, 9);
    if (sel == 0) q = 0;
    else if (sel < 4) q[31] = 1'b1;
    else if (sel < 7) q[31:30] = 2'b01;
    else q[31:29] = 3'b001;
    ex = int'($urandom_range(0, 400)) - 60;
    s = 1'($urandom);
    n = $urandom_range(0, 15) == 0;
    i = $urandom_range(0, 15) == 0;
    z = $urandom_range(0, 15) == 0;
    rm = 2'($urandom);
    issue(q, ex, s, n, i, z, rm, model(q, ex, s, n, i, z, rm));
  endtask

  task automatic idle(input int cnt);
    repeat (cnt) begin
      @(negedge clk);
      en = 1; in_valid = 0; in_q = $urandom;
    end
  endtask

  task automatic hold(input int cnt);
    logic [35:0] snap;
    @(negedge clk);
    snap = {out_valid, out_of, out_uf, out_nx, out_result};
    en = 0; in_valid = 1; in_q = $urandom;
    repeat (cnt) begin
      @(negedge clk);
      in_q = $urandom;
      chk("hold", 64'({out_valid, out_of, out_uf, out_nx, out_result}), 64'(snap));
    end
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("reset_state", 64'({out_valid, out_of, out_uf, out_nx, out_result}), 64'd0);
    rst_n = 1;
    issue(32'h6000_0000, 128, 0, 0, 0, 0, 2'b00, {3'b000, 32'h4040_0000});
    issue(32'h2AAA_AAAB, 127, 0, 0, 0, 0, 2'b00, {3'b001, 32'h3F2A_AAAB});
    issue(32'h4000_0000, 300, 1, 0, 0, 0, 2'b00, {3'b101, 32'hFF80_0000});
    issue(32'h4000_0000, 0, 1, 0, 0, 0, 2'b00, {3'b011, 32'h8000_0000});
    issue(32'h1234_5678, 127, 0, 1, 1, 0, 2'b00, {3'b000, 32'h7FC0_0000});
    issue(32'h1234_5678, 127, 1, 0, 1, 1, 2'b00, {3'b000, 32'hFF80_0000});
    issue(32'h7FFF_FFFF, 127, 0, 0, 0, 0, 2'b00, {3'b001, 32'h4000_0000});
    issue(32'h0000_0000, 127, 1, 0, 0, 0, 2'b00, {3'b000, 32'h8000_0000});
    issue(32'h4000_0000, 254, 0, 0, 0, 0, 2'b00, {3'b000, 32'h7F00_0000});
    issue(32'h4000_0000, 1, 0, 0, 0, 0, 2'b00, {3'b000, 32'h0080_0000});
`ifdef FDIV_RM_EN
    issue(32'h2AAA_AAAB, 127, 0, 0, 0, 0, 2'b01, {3'b001, 32'h3F2A_AAAA});
    issue(32'h4000_0000, 300, 1, 0, 0, 0, 2'b01, {3'b101, 32'hFF7F_FFFF});
    issue(32'h2AAA_AAAB, 127, 0, 0, 0, 0, 2'b10, {3'b001, 32'h3F2A_AAAB});
    issue(32'h2AAA_AAAB, 127, 1, 0, 0, 0, 2'b10, {3'b001, 32'hBF2A_AAAA});
`else
    issue(32'h2AAA_AAAB, 127, 0, 0, 0, 0, 2'b01, {3'b001, 32'h3F2A_AAAB});
    issue(32'h4000_0000, 300, 1, 0, 0, 0, 2'b01, {3'b101, 32'hFF80_0000});
`endif
    issue(32'h6000_0000, 128, 0, 0, 0, 0, 2'b00, {3'b000, 32'h4040_0000});
    hold(3);
    issue(32'h4000_0000, 0, 1, 0, 0, 0, 2'b00, {3'b011, 32'h8000_0000});
    idle(3);
    for (int t = 0; t < 400; t++) begin
      int r;
      r = $urandom_range(0, 9);
      if (r == 0) idle(1);
      else if (r == 1) hold($urandom_range(1, 3));
      else rnd_issue();
    end
    rnd_issue();
    rnd_issue();
    @(negedge clk);
    rst_n = 0;
    en = 1; in_valid = 0;
    expq.delete();
    #1;
    chk("reset_midop", 64'({out_valid, out_of, out_uf, out_nx, out_result}), 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1;
    idle(5);
    rnd_issue();
    idle(3);
    chk("drain", 64'(expq.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
